// File: rtl/dbg_trace_pkg.sv
// Shared types and constants for the debug trace capture buffer.
// Optional build macro: DBG_TRACE_TIMESTAMP_EN adds a per-entry 32-bit
// cycle timestamp, read back as one extra 32-bit lane after the probe lanes.
package dbg_trace_pkg;

    // Capture controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_t;

    // Width of the stored timestamp field
    localparam int TS_W = 32;

    // Number of readable 32-bit lanes that carry stored data
    function automatic int lane_count(input int entry_w);
`ifdef DBG_TRACE_TIMESTAMP_EN
        return entry_w / 32 + 1;
`else
        return entry_w / 32;
`endif
    endfunction

endpackage

// File: rtl/dbg_trace_buffer_if.sv
// MMIO readout bus between the CPU interface decode (master) and the
// trace buffer (slave). Address is {entry index, 32-bit lane}.
interface dbg_trace_buffer_if #(
    parameter int ADDR_W = 9
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/dbg_trace_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read
// port. A read and write to the same address in one cycle returns the old
// word (read-before-write). No reset so it maps onto block RAM.
module dbg_trace_ram #(
    parameter int WIDTH  = 128,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_reg [2**ADDR_W];

    // Write port and registered read port share one clock edge
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem_reg[raddr];
        end
    end

endmodule

// File: rtl/dbg_trace_buffer.sv
// Debug trace capture buffer: records entry_in every cycle the selected
// trigger is high, tracks the latest burst start, write pointer, fill level,
// overflow and trigger-edge count. Readout is 32 bits per access via the
// MMIO interface with one cycle of latency.
// Optional build macro: DBG_TRACE_TIMESTAMP_EN stores a free-running cycle
// count with each entry, readable at lane ENTRY_W/32.
module dbg_trace_buffer
    import dbg_trace_pkg::*;
#(
    parameter  int ENTRY_W    = 128,
    parameter  int DEPTH_LOG2 = 6,
    parameter  int NUM_TRIG   = 2,
    parameter  int CNT_W      = 7,
    localparam int TSEL_W     = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_TRIG-1:0]   trig_in,
    input  logic [TSEL_W-1:0]     trig_sel,
    input  logic [ENTRY_W-1:0]    entry_in,
    input  logic                  mode_oneshot,
    input  logic                  arm,
    input  logic                  disarm,
    dbg_trace_buffer_if.slave     rd_bus,
    output logic [DEPTH_LOG2-1:0] que_start,
    output logic [DEPTH_LOG2-1:0] que_end,
    output logic                  full,
    output logic                  overflow,
    output logic [CNT_W-1:0]      burst_cnt,
    output logic                  busy
);

    localparam int DEPTH    = 1 << DEPTH_LOG2;
    localparam int LANE_W   = $clog2(ENTRY_W / 32 + 1);
    localparam int RD_LANES = lane_count(ENTRY_W);
`ifdef DBG_TRACE_TIMESTAMP_EN
    localparam int RAM_W    = ENTRY_W + TS_W;
`else
    localparam int RAM_W    = ENTRY_W;
`endif
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LAST_COUNT = (DEPTH_LOG2 + 1)'(DEPTH - 1);

    trace_state_t          state_reg;
    logic [DEPTH_LOG2-1:0] que_start_reg;
    logic [DEPTH_LOG2-1:0] que_end_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [CNT_W-1:0]      burst_cnt_reg;
    logic                  overflow_reg;
    logic                  trig_last_reg;

    logic                  trig;
    logic                  cap_state;
    logic                  is_full;
    logic                  wr_en;
    logic                  last_write;
    logic                  edge_seen;
    logic [RAM_W-1:0]      wr_data;
    logic [RAM_W-1:0]      ram_rdata;

    // Capture qualification; arm drops any capture in its own cycle, and a
    // one-shot buffer that is already full never writes again
    always_comb begin
        trig       = trig_in[trig_sel];
        cap_state  = (state_reg == ST_ARMED) || (state_reg == ST_CAPTURE);
        is_full    = (count_reg == FULL_COUNT);
        wr_en      = cap_state && trig && !arm && !(mode_oneshot && is_full);
        last_write = mode_oneshot && (count_reg == LAST_COUNT);
        edge_seen  = cap_state && (trig != trig_last_reg);
    end

    // Capture controller: state, pointers, fill level, flags, edge counter.
    // disarm during a capture cycle still lets that cycle's entry land.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            que_start_reg <= '0;
            que_end_reg   <= '0;
            count_reg     <= '0;
            burst_cnt_reg <= '0;
            overflow_reg  <= 1'b0;
            trig_last_reg <= 1'b0;
        end else begin
            trig_last_reg <= trig;
            if (arm) begin
                state_reg     <= ST_ARMED;
                que_start_reg <= '0;
                que_end_reg   <= '0;
                count_reg     <= '0;
                burst_cnt_reg <= '0;
                overflow_reg  <= 1'b0;
            end else begin
                if (edge_seen) begin
                    burst_cnt_reg <= burst_cnt_reg + 1'b1;
                end
                if (wr_en) begin
                    que_end_reg <= que_end_reg + 1'b1;
                    if (state_reg == ST_ARMED) begin
                        que_start_reg <= que_end_reg;
                    end
                    if (is_full) begin
                        overflow_reg <= 1'b1;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                if (disarm) begin
                    state_reg <= ST_IDLE;
                end else if (cap_state && trig) begin
                    state_reg <= (!wr_en || last_write) ? ST_DONE : ST_CAPTURE;
                end else if (state_reg == ST_CAPTURE) begin
                    state_reg <= ST_ARMED;
                end
            end
        end
    end

`ifdef DBG_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_reg;

    // Free-running cycle counter stored alongside each entry
    always_ff @(posedge clk) begin
        if (!rst) begin
            ts_reg <= '0;
        end else begin
            ts_reg <= ts_reg + 1'b1;
        end
    end

    assign wr_data = {ts_reg, entry_in};
`else
    assign wr_data = entry_in;
`endif

    dbg_trace_ram #(
        .WIDTH  (RAM_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (que_end_reg),
        .wdata (wr_data),
        .re    (rd_bus.rd_en),
        .raddr (rd_bus.rd_addr[LANE_W +: DEPTH_LOG2]),
        .rdata (ram_rdata)
    );

    logic [LANE_W-1:0] lane_reg;
    logic              rd_seen_reg;

    // Lane select registered with the RAM read so rd_data holds between reads;
    // rd_seen_reg keeps rd_data at 0 until the first read after reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            lane_reg    <= '0;
            rd_seen_reg <= 1'b0;
        end else if (rd_bus.rd_en) begin
            lane_reg    <= rd_bus.rd_addr[LANE_W-1:0];
            rd_seen_reg <= 1'b1;
        end
    end

    logic [31:0] lane_word [2**LANE_W];

    for (genvar gi = 0; gi < 2**LANE_W; gi++) begin : g_lane
        if (gi < RD_LANES) begin : g_data
            assign lane_word[gi] = ram_rdata[gi*32 +: 32];
        end else begin : g_zero
            assign lane_word[gi] = '0;
        end
    end

    assign rd_bus.rd_data = rd_seen_reg ? lane_word[lane_reg] : 32'd0;

    assign que_start = que_start_reg;
    assign que_end   = que_end_reg;
    assign full      = is_full;
    assign overflow  = overflow_reg;
    assign burst_cnt = burst_cnt_reg;
    assign busy      = (state_reg == ST_CAPTURE);

endmodule

// File: doc/dbg_trace_buffer.md
Name: dbg_trace_buffer

Overview:
Parametrised debug trace capture buffer, the successor to the fixed 64x128 stall-trace queue in the CPU/memory interface. It records an ENTRY_W-bit probe vector every cycle while a selected trigger channel is high. It tracks burst start/end pointers and a burst counter, and supports wrap-around and one-shot modes. Captured data is read back 32 bits at a time through the MMIO data path of the CPU interface decode.

Parameters:
ENTRY_W, 128, probe vector width in bits; multiple of 32
DEPTH_LOG2, 6, log2 of entry count (DEPTH = 2**DEPTH_LOG2)
NUM_TRIG, 2, number of trigger channels (e.g. cache stall, vmem stall)
CNT_W, 7, burst counter width; wraps

Ports:
clk  in  1  pipeline clock; all logic on posedge
rst  in  1  synchronous reset, active-low
trig_in  in  NUM_TRIG  trigger channel levels
trig_sel  in  $clog2(NUM_TRIG) (min 1)  selects the active trigger channel
entry_in  in  ENTRY_W  probe vector to record
mode_oneshot  in  1  0 = wrap (overwrite oldest), 1 = stop when full
arm  in  1  pulse: clear pointers/flags, enter ARMED
disarm  in  1  pulse: enter IDLE, data retained
rd_en  in  1  readout strobe
rd_addr  in  DEPTH_LOG2+LANE_W  {entry index, 32-bit lane}; LANE_W = $clog2(ENTRY_W/32 + 1)
rd_data  out  32  readout data
que_start  out  DEPTH_LOG2  slot of the first entry of the latest burst
que_end  out  DEPTH_LOG2  next slot to write
full  out  1  stored count == DEPTH
overflow  out  1  sticky; set on a write while full (wrap mode)
burst_cnt  out  CNT_W  count of trigger transitions (both edges)
busy  out  1  state is CAPTURE

Behaviour:
- Reset (rst == 0 at posedge): state IDLE. que_start, que_end, count, burst_cnt, overflow all 0. rd_data 0. trig_last 0. RAM contents undefined.
- States: IDLE, ARMED, CAPTURE, DONE.
  - IDLE -> ARMED on arm.
  - ARMED -> CAPTURE when the selected trigger is high.
  - CAPTURE -> ARMED when the trigger goes low.
  - CAPTURE -> DONE when one-shot and the write fills the buffer.
  - Any state -> IDLE on disarm.
  - arm and disarm in the same cycle: arm wins.
- trig = trig_in[trig_sel]. trig_last registers trig every cycle, in all states. burst_cnt increments by 1 (mod 2**CNT_W) whenever trig != trig_last while in ARMED or CAPTURE.
- Capture: in ARMED or CAPTURE with trig high, write entry_in to RAM[que_end], then que_end += 1 (mod DEPTH). count saturates at DEPTH.
- Burst start: on the first capture cycle of a burst (ARMED with trig high), que_start <= que_end (pre-increment value), in the same cycle as that write.
- Wrap mode with full: the write still occurs. overflow <= 1. que_start is unaffected (it may point at an overwritten slot; software checks overflow).
- One-shot mode: the write that makes count == DEPTH is the last. The state goes to DONE and no further writes happen until arm.
- arm in any state: que_start, que_end, count, overflow cleared to 0; burst_cnt cleared to 0; state ARMED. A capture in the same cycle as arm is dropped.
- Readout: on rd_en, rd_data <= lane rd_addr[LANE_W-1:0] of RAM[rd_addr entry]. Latency 1 cycle. Lane 0 = bits [31:0]. Lane indices >= ENTRY_W/32 read 0 unless the optional feature is enabled. rd_data holds its value when rd_en is low.
- A read and a write to the same slot in the same cycle return the old data.
- full = (count == DEPTH). busy = (state == CAPTURE).

Optional Feature:
DBG_TRACE_TIMESTAMP_EN
- Defined: a 32-bit free-running cycle counter (reset 0, wraps) is stored alongside each entry. Lane index ENTRY_W/32 returns the timestamp of that entry.
- Undefined: no counter or extra storage. That lane reads 0.

Decomposition:
- Package dbg_trace_pkg:
  - state enum (IDLE/ARMED/CAPTURE/DONE)
  - TS_W = 32
  - lane-count constant function ENTRY_W/32 (+1 with the timestamp feature)
- Sub-module dbg_trace_ram: simple dual-port synchronous RAM, one write port and one registered read port, read-before-write, width ENTRY_W (+TS_W), depth DEPTH. Infers Block RAM.

Test Plan:
- Reset, arm, trig_sel=0; hold trig_in[0] high 5 cycles with entry_in = 0x10..0x14; release -> que_start=0, que_end=5, burst_cnt=2. Read {2, lane 0} -> rd_data=0x12 one cycle later.
- Second burst of 3 cycles -> que_start=5, que_end=8, burst_cnt=4, busy=1 only during the burst.
- Wrap mode, DEPTH=64, 70-cycle burst -> que_end=6, full=1, overflow=1. Slot 0 holds the 65th entry.
- One-shot mode, 70-cycle burst -> exactly 64 writes, state DONE, que_end=0, overflow=0. A further trigger burst writes nothing. arm -> pointers 0, state ARMED.
- trig_sel=1 with trig_in[0] toggling -> no captures and burst_cnt unchanged. arm and disarm asserted together -> ARMED. disarm mid-burst -> capture stops, data readable.
- Read lane ENTRY_W/32 -> 0 without DBG_TRACE_TIMESTAMP_EN. With it, the cycle counter value at the write cycle. Same-slot read/write in one cycle -> old data.
